perf_counter_ctrl: RTL and testbench
====================================

# perf_counter_ctrl

Controller for the CPU's bank of performance event counters. Each of `NUM_EVENTS` counters counts rising edges of one pipeline event line (stall, I-cache miss, D-cache miss, branch mispredict, …), counting once per assertion however many cycles the line stays high. The block shares a single request/acknowledge port among all counters. Through that port, the MEM stage (memory-mapped counter region) reads a counter, clears one or all counters, or loads the enable mask.

## Interface
- `NUM_EVENTS`, default 8: number of counters/event lines (2..16).
- `WIDTH`, default 16: counter and data width.
- `IDXW`, default `$clog2(NUM_EVENTS)`: index width.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `event_in`  in  NUM_EVENTS  level event lines, one per counter.
- `req`  in  1  request; held high until `ack`.
- `req_op`  in  2  `perf_op_t`: READ=0, CLEAR_ONE=1, CLEAR_ALL=2, SET_MASK=3.
- `req_idx`  in  IDXW  counter index for READ / CLEAR_ONE.
- `req_wdata`  in  WIDTH  SET_MASK data; low NUM_EVENTS bits used.
- `ack`  out  1  one-cycle completion pulse.
- `rdata`  out  WIDTH  READ result, valid while `ack`=1.
- `busy`  out  1  FSM not in IDLE.
- `ovf`  out  NUM_EVENTS  sticky per-counter wrap flags.

## Operation
- Edge detect: `event_prev` register per line. A counter's edge is `event_in[i] & ~event_prev[i]`. The counter increments on an edge only if `mask[i]`=1. `event_prev` updates every cycle regardless of mask.
- Arithmetic: modulo 2^WIDTH. Increment from all-ones gives 0 and sets `ovf[i]`. `ovf[i]` stays set until that counter is cleared.
- FSM states: IDLE, EXEC, ACK.
  - IDLE: if `req`=1, capture op/idx/wdata and go to EXEC. Otherwise stay.
  - EXEC: perform the captured op and go to ACK.
    - READ: latch `count[idx]` into `rdata`.
    - CLEAR_ONE: zero `count[idx]` and `ovf[idx]`.
    - CLEAR_ALL: zero all counts and all `ovf`.
    - SET_MASK: `mask` ← `wdata[NUM_EVENTS-1:0]`.
  - ACK: `ack`=1, then go to IDLE.
- Requester drops `req` in the cycle after `ack`. If `req` is still high in IDLE, it is accepted as a new request.
- Inputs are captured only at IDLE acceptance. Changes to `req_op`/`req_idx`/`req_wdata` while busy are ignored.
- `idx` ≥ NUM_EVENTS: READ returns 0; CLEAR_ONE does nothing; `ack` still pulses.
- Simultaneous events:
  - Clear and edge on the same counter in the EXEC cycle: the clear wins; the counter ends at 0 and the edge is lost.
  - READ and edge in the same EXEC cycle: `rdata` is the pre-increment value.
  - SET_MASK in EXEC applies from the next cycle; an edge in the EXEC cycle uses the old mask.
  - Counters not targeted by the current op keep counting during EXEC/ACK.

## Timing
- Reset values:
  - FSM = IDLE.
  - `ack`=0, `busy`=0, `rdata`=0.
  - All counts = 0, `ovf`=0, `event_prev`=0, `mask`=all ones.
- An event line already high in the first cycle after reset counts once.
- Latency: `req` sampled high in IDLE at edge N → EXEC during cycle N+1 → `ack`=1 during cycle N+2. Requests are fixed at 3 cycles, at most one request per 3 cycles.
- `busy`=1 during EXEC and ACK.
- Count effect: an edge seen at clock edge N shows in the count after edge N (one-cycle increment).
- Reset asserted mid-request: next state is IDLE; no `ack` is produced; the request is dropped. The requester must reissue after reset.

## Structure
- Shared package `lc3b_types`: `perf_op_t` enum (2-bit) and event-index constants (`PERF_EV_STALL`=0, `PERF_EV_IMISS`=1, `PERF_EV_DMISS`=2, `PERF_EV_MISPRED`=3).
- The FSM state enum is local to the module.
- Sub-module `perf_event_counter` (instantiated NUM_EVENTS times) contains:
  - ports: `clk`, `reset`, `event_in`, `enable`, `clear`, `count[WIDTH]`, `ovf`;
  - internal edge detect, wrap and sticky overflow;
  - clear priority over increment.
- The top level holds the FSM, request capture, mask register and read mux.

## Test plan
- Reset, then hold `event_in[0]` high 5 cycles, low 2, high 1 → READ idx 0 returns 2 with `ack` exactly 2 cycles after acceptance; `busy` high 2 cycles.
- 3 edges on lines 1 and 2; CLEAR_ONE idx 1 → READ 1 = 0, READ 2 = 3. Then CLEAR_ALL → both read 0 and `ovf`=0.
- SET_MASK wdata=0x0001, then edges on lines 0 and 3 → line 0 reads 1, line 3 reads 0. Mask changing from 0xFF occurs exactly after EXEC.
- `WIDTH`=4 build: 17 edges on line 0 → READ = 1, `ovf[0]`=1. CLEAR_ONE 0 → `ovf[0]`=0.
- Edge on line 1 coincident with the EXEC cycle of CLEAR_ONE idx 1 → reads 0. Coincident with READ EXEC → `rdata` is the old value, and a later read shows +1.
- Assert `reset` during EXEC of READ → no `ack`, FSM IDLE, counts 0. `req` held high through reset → accepted in the first IDLE cycle, `ack` 2 cycles later.

Source files
------------

// File: rtl/lc3b_types_pkg.sv
// Shared LC-3b core types used by the performance counter block.
// Provides the request opcode enum for the counter port and the fixed
// event-line assignments used by the pipeline when wiring event_in.
package lc3b_types;

  localparam int unsigned PERF_OP_W = 2;

  // Operation requested through the shared counter port
  typedef enum logic [PERF_OP_W-1:0] {
    PERF_READ      = 2'd0,
    PERF_CLEAR_ONE = 2'd1,
    PERF_CLEAR_ALL = 2'd2,
    PERF_SET_MASK  = 2'd3
  } perf_op_t;

  // Event-line indices into event_in
  localparam int unsigned PERF_EV_STALL   = 0;
  localparam int unsigned PERF_EV_IMISS   = 1;
  localparam int unsigned PERF_EV_DMISS   = 2;
  localparam int unsigned PERF_EV_MISPRED = 3;

endpackage

// File: rtl/perf_event_counter.sv
// One performance counter: counts rising edges of a level event line.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   event_in    - level event line
//   enable      - mask bit; an edge counts only while set
//   clear       - zero count and ovf (wins over a simultaneous edge)
//   count       - current count, wraps modulo 2^WIDTH
//   ovf         - sticky wrap flag, cleared only by clear
module perf_event_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             event_in,
  input  logic             enable,
  input  logic             clear,
  output logic [WIDTH-1:0] count,
  output logic             ovf
);

  logic event_prev;
  logic rise_c;

  assign rise_c = event_in & ~event_prev;

  // Edge history tracks the line every cycle, independent of enable
  always_ff @(posedge clk) begin
    if (reset) begin
      event_prev <= 1'b0;
      count      <= '0;
      ovf        <= 1'b0;
    end else begin
      event_prev <= event_in;
      if (clear) begin
        count <= '0;
        ovf   <= 1'b0;
      end else if (rise_c && enable) begin
        count <= count + WIDTH'(1);
        if (count == '1) ovf <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/perf_counter_ctrl.sv
// Performance counter bank with a shared request/ack port.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   event_in    - one level event line per counter
//   req         - request, held until ack
//   req_op      - READ / CLEAR_ONE / CLEAR_ALL / SET_MASK
//   req_idx     - counter index for READ / CLEAR_ONE
//   req_wdata   - new enable mask for SET_MASK (low NUM_EVENTS bits)
//   ack         - one-cycle completion pulse
//   rdata       - READ result, valid while ack
//   busy        - controller in EXEC or ACK
//   ovf         - sticky per-counter wrap flags
module perf_counter_ctrl
  import lc3b_types::*;
#(
  parameter int unsigned NUM_EVENTS = 8,
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned IDXW       = $clog2(NUM_EVENTS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_EVENTS-1:0] event_in,
  input  logic                  req,
  input  perf_op_t              req_op,
  input  logic [IDXW-1:0]       req_idx,
  input  logic [WIDTH-1:0]      req_wdata,
  output logic                  ack,
  output logic [WIDTH-1:0]      rdata,
  output logic                  busy,
  output logic [NUM_EVENTS-1:0] ovf
);

  localparam int unsigned MW = (NUM_EVENTS > WIDTH) ? NUM_EVENTS : WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t                state;
  perf_op_t              cap_op;
  logic [IDXW-1:0]       cap_idx;
  logic [WIDTH-1:0]      cap_wdata;
  logic [NUM_EVENTS-1:0] mask;
  logic [NUM_EVENTS-1:0] clear_c;
  logic [WIDTH-1:0]      count_arr [NUM_EVENTS];
  logic [WIDTH-1:0]      rd_c;
  logic [MW-1:0]         wdata_ext_c;
  logic                  unused_wdata_c;

  // Zero-extend so a mask wider than the data bus still elaborates
  assign wdata_ext_c    = MW'(cap_wdata);
  assign unused_wdata_c = ^wdata_ext_c;

  // Clear strobes only in EXEC; an out-of-range index matches no counter
  always_comb begin
    clear_c = '0;
    if (state == S_EXEC) begin
      for (int i = 0; i < NUM_EVENTS; i++) begin
        if (cap_op == PERF_CLEAR_ALL ||
            (cap_op == PERF_CLEAR_ONE && cap_idx == IDXW'(i)))
          clear_c[i] = 1'b1;
      end
    end
  end

  // Read mux; an out-of-range index reads as zero
  always_comb begin
    rd_c = '0;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      if (cap_idx == IDXW'(i)) rd_c = count_arr[i];
    end
  end

  // Request FSM: capture in IDLE, act in EXEC, pulse ack in ACK
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      ack       <= 1'b0;
      busy      <= 1'b0;
      rdata     <= '0;
      mask      <= '1;
      cap_op    <= PERF_READ;
      cap_idx   <= '0;
      cap_wdata <= '0;
    end else begin
      ack <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            cap_op    <= req_op;
            cap_idx   <= req_idx;
            cap_wdata <= req_wdata;
            busy      <= 1'b1;
            state     <= S_EXEC;
          end
        end
        S_EXEC: begin
          // Counters update on this same edge, so rdata is pre-increment
          // and a new mask only affects edges from the next cycle
          if (cap_op == PERF_READ) rdata <= rd_c;
          if (cap_op == PERF_SET_MASK) mask <= wdata_ext_c[NUM_EVENTS-1:0];
          ack   <= 1'b1;
          state <= S_ACK;
        end
        S_ACK: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_EVENTS; g++) begin : g_ctr
    perf_event_counter #(.WIDTH(WIDTH)) u_ctr (
      .clk      (clk),
      .reset    (reset),
      .event_in (event_in[g]),
      .enable   (mask[g]),
      .clear    (clear_c[g]),
      .count    (count_arr[g]),
      .ovf      (ovf[g])
    );
  end

endmodule

// File: tb/tb_perf_counter_ctrl.sv
// Bench for perf_counter_ctrl: a default build (8 x 16-bit) and a narrow
// build (6 x 4-bit, so indices 6/7 are out of range) share one stimulus.
module tb_perf_counter_ctrl;
  import lc3b_types::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  event_in;
  logic        req;
  perf_op_t    req_op;
  logic [2:0]  req_idx;
  logic [15:0] req_wdata;

  logic        ack_m, busy_m;
  logic [15:0] rdata_m;
  logic [7:0]  ovf_m;
  logic        ack_s, busy_s;
  logic [3:0]  rdata_s;
  logic [5:0]  ovf_s;

  always #5 clk = ~clk;

  perf_counter_ctrl u_dut (
    .clk(clk), .reset(reset), .event_in(event_in), .req(req),
    .req_op(req_op), .req_idx(req_idx), .req_wdata(req_wdata),
    .ack(ack_m), .rdata(rdata_m), .busy(busy_m), .ovf(ovf_m)
  );

  perf_counter_ctrl #(.NUM_EVENTS(6), .WIDTH(4)) u_small (
    .clk(clk), .reset(reset), .event_in(event_in[5:0]), .req(req),
    .req_op(req_op), .req_idx(req_idx), .req_wdata(req_wdata[3:0]),
    .ack(ack_s), .rdata(rdata_s), .busy(busy_s), .ovf(ovf_s)
  );

  typedef struct {
    logic        chk;
    logic [15:0] exp_m;
    logic [3:0]  exp_s;
  } sb_t;

  typedef struct {
    logic [7:0]  pulse;
    perf_op_t    op;
    logic [2:0]  idx;
    logic [15:0] wdata;
    logic        chk;
    logic [15:0] exp_m;
    logic [3:0]  exp_s;
  } vec_t;

  sb_t  sbq[$];
  vec_t vt [18];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [7:0] lines);
    event_in = lines;
    tick();
    event_in = 8'h00;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Issue one request; optionally raise lines so their edge lands on the EXEC edge
  task automatic do_req(input perf_op_t op, input logic [2:0] idx, input logic [15:0] wd,
                        input logic chk, input logic [15:0] em, input logic [3:0] es,
                        input logic [7:0] ev_exec);
    sb_t e;
    e.chk = chk; e.exp_m = em; e.exp_s = es;
    sbq.push_back(e);
    req = 1'b1; req_op = op; req_idx = idx; req_wdata = wd;
    tick();
    check("exec_busy_noack", {28'd0, busy_m, busy_s, ack_m, ack_s}, 32'hC);
    event_in  = event_in | ev_exec;
    req_op    = PERF_CLEAR_ALL;
    req_idx   = ~idx;
    req_wdata = 16'h0000;
    tick();
    check("ack_at_plus2", {28'd0, busy_m, busy_s, ack_m, ack_s}, 32'hF);
    req = 1'b0;
    tick();
    check("idle_after_ack", {28'd0, busy_m, busy_s, ack_m, ack_s}, 32'h0);
  endtask

  // Scoreboard: every ack pops one expected entry
  always @(negedge clk) begin : mon
    sb_t e;
    if (!reset && (ack_m || ack_s)) begin
      if (sbq.size() == 0) begin
        check("unexpected_ack", {30'd0, ack_m, ack_s}, 32'h0);
      end else begin
        e = sbq.pop_front();
        check("ack_m", {31'd0, ack_m}, 32'h1);
        check("ack_s", {31'd0, ack_s}, 32'h1);
        if (e.chk) begin
          check("rdata_m", {16'd0, rdata_m}, {16'd0, e.exp_m});
          check("rdata_s", {28'd0, rdata_s}, {28'd0, e.exp_s});
        end
      end
    end
  end

  initial begin
    vt[0]  = '{8'h06, PERF_READ,      3'd1, 16'h0000, 1'b1, 16'd1, 4'd1};
    vt[1]  = '{8'h06, PERF_READ,      3'd2, 16'h0000, 1'b1, 16'd2, 4'd2};
    vt[2]  = '{8'h06, PERF_CLEAR_ONE, 3'd1, 16'h0000, 1'b0, 16'd0, 4'd0};
    vt[3]  = '{8'h00, PERF_READ,      3'd1, 16'h0000, 1'b1, 16'd0, 4'd0};
    vt[4]  = '{8'h00, PERF_READ,      3'd2, 16'h0000, 1'b1, 16'd3, 4'd3};
    vt[5]  = '{8'h00, PERF_READ,      3'd0, 16'h0000, 1'b1, 16'd2, 4'd2};
    vt[6]  = '{8'h00, PERF_CLEAR_ALL, 3'd0, 16'h0000, 1'b0, 16'd0, 4'd0};
    vt[7]  = '{8'h00, PERF_READ,      3'd2, 16'h0000, 1'b1, 16'd0, 4'd0};
    vt[8]  = '{8'h00, PERF_READ,      3'd0, 16'h0000, 1'b1, 16'd0, 4'd0};
    vt[9]  = '{8'h00, PERF_SET_MASK,  3'd0, 16'h0001, 1'b0, 16'd0, 4'd0};
    vt[10] = '{8'h09, PERF_READ,      3'd0, 16'h0000, 1'b1, 16'd1, 4'd1};
    vt[11] = '{8'h00, PERF_READ,      3'd3, 16'h0000, 1'b1, 16'd0, 4'd0};
    vt[12] = '{8'h00, PERF_SET_MASK,  3'd0, 16'h00FF, 1'b0, 16'd0, 4'd0};
    vt[13] = '{8'h88, PERF_READ,      3'd3, 16'h0000, 1'b1, 16'd1, 4'd1};
    vt[14] = '{8'h80, PERF_READ,      3'd7, 16'h0000, 1'b1, 16'd2, 4'd0};
    vt[15] = '{8'h00, PERF_CLEAR_ONE, 3'd6, 16'h0000, 1'b0, 16'd0, 4'd0};
    vt[16] = '{8'h00, PERF_READ,      3'd0, 16'h0000, 1'b1, 16'd1, 4'd1};
    vt[17] = '{8'h20, PERF_READ,      3'd5, 16'h0000, 1'b1, 16'd1, 4'd0};

    reset = 1'b1; req = 1'b0; req_op = PERF_READ; req_idx = 3'd0; req_wdata = 16'h0;
    event_in = 8'h01;

    // Line 0 already high out of reset: high 5, low 2, high 1 -> two edges
    do_reset();
    check("rst_ack_busy", {28'd0, ack_m, busy_m, ack_s, busy_s}, 32'h0);
    check("rst_rdata", {12'd0, rdata_s, rdata_m}, 32'h0);
    check("rst_ovf", {18'd0, ovf_s, ovf_m}, 32'h0);
    repeat (5) tick();
    event_in = 8'h00;
    repeat (2) tick();
    event_in = 8'h01;
    tick();
    event_in = 8'h00;
    tick();
    do_req(PERF_READ, 3'd0, 16'h0, 1'b1, 16'd2, 4'd2, 8'h00);

    for (int i = 0; i < 18; i++) begin
      if (vt[i].pulse != 8'h00) pulse(vt[i].pulse);
      do_req(vt[i].op, vt[i].idx, vt[i].wdata, vt[i].chk, vt[i].exp_m, vt[i].exp_s, 8'h00);
      check("vec_ovf", {18'd0, ovf_s, ovf_m}, 32'h0);
    end

    // Wrap: 17 edges -> 17 on the wide build, 1 with ovf on the 4-bit build
    do_reset();
    repeat (17) pulse(8'h01);
    do_req(PERF_READ, 3'd0, 16'h0, 1'b1, 16'd17, 4'd1, 8'h00);
    check("wrap_ovf_m", {31'd0, ovf_m[0]}, 32'h0);
    check("wrap_ovf_s", {31'd0, ovf_s[0]}, 32'h1);
    do_req(PERF_CLEAR_ONE, 3'd0, 16'h0, 1'b0, 16'd0, 4'd0, 8'h00);
    check("clr_ovf_s", {31'd0, ovf_s[0]}, 32'h0);
    do_req(PERF_READ, 3'd0, 16'h0, 1'b1, 16'd0, 4'd0, 8'h00);

    // Edge on the EXEC edge of CLEAR_ONE: clear wins
    pulse(8'h02);
    pulse(8'h02);
    do_req(PERF_CLEAR_ONE, 3'd1, 16'h0, 1'b0, 16'd0, 4'd0, 8'h02);
    event_in = 8'h00;
    tick();
    do_req(PERF_READ, 3'd1, 16'h0, 1'b1, 16'd0, 4'd0, 8'h00);

    // Edge on the EXEC edge of READ: old value returned, increment lands
    pulse(8'h02);
    do_req(PERF_READ, 3'd1, 16'h0, 1'b1, 16'd1, 4'd1, 8'h02);
    event_in = 8'h00;
    tick();
    do_req(PERF_READ, 3'd1, 16'h0, 1'b1, 16'd2, 4'd2, 8'h00);

    // SET_MASK: edge in its EXEC cycle uses the old mask, later edge is masked
    do_req(PERF_SET_MASK, 3'd0, 16'h0001, 1'b0, 16'd0, 4'd0, 8'h04);
    event_in = 8'h00;
    tick();
    pulse(8'h04);
    do_req(PERF_READ, 3'd2, 16'h0, 1'b1, 16'd1, 4'd1, 8'h00);

    // Reset during EXEC of a READ: request dropped, counts cleared
    do_reset();
    pulse(8'h01);
    req = 1'b1; req_op = PERF_READ; req_idx = 3'd0;
    tick();
    check("pre_abort_busy", {30'd0, busy_m, busy_s}, 32'h3);
    reset = 1'b1;
    req   = 1'b0;
    tick();
    check("abort_state", {28'd0, busy_m, busy_s, ack_m, ack_s}, 32'h0);
    reset = 1'b0;
    repeat (3) tick();
    check("abort_no_ack", {28'd0, busy_m, busy_s, ack_m, ack_s}, 32'h0);
    do_req(PERF_READ, 3'd0, 16'h0, 1'b1, 16'd0, 4'd0, 8'h00);

    // req held through reset: taken in the first IDLE cycle
    pulse(8'h01);
    reset = 1'b1;
    req = 1'b1; req_op = PERF_READ; req_idx = 3'd0;
    tick();
    reset = 1'b0;
    do_req(PERF_READ, 3'd0, 16'h0, 1'b1, 16'd0, 4'd0, 8'h00);

    repeat (2) tick();
    check("sb_drained", sbq.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
